pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the decode/register-read stage. Each cycle it produces the stage's `stall` and `bubble` controls from three things: pending-load tracking, taken-jump flushes and a variable-latency data-memory response. Loads are in-order and blocking, with register-dependency (load-use) stalls. The block sits beside the decode stage, watches the instruction in decode and the instruction in execute, and holds fetch/decode or injects bubbles into execute as required.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: register-address width and helpers.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute/data-memory signals watched by the hazard controller, plus its stage controls.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic      dec_valid;
    reg_addr_t dec_rs1;
    reg_addr_t dec_rs2;
    logic      dec_uses_rs1;
    logic      dec_uses_rs2;
    logic      dec_is_mem;
    logic      dec_is_jump;
    reg_addr_t ex_rd;
    logic      ex_mem_rr;
    logic      ex_jump_taken;
    logic      dmem_resp_valid;
    logic      stall;
    logic      bubble;
    logic      load_pending;
    logic      timeout_err;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_is_mem, dec_is_jump, ex_rd, ex_mem_rr, ex_jump_taken,
               dmem_resp_valid,
        input  stall, bubble, load_pending, timeout_err
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_is_mem, dec_is_jump, ex_rd, ex_mem_rr, ex_jump_taken,
               dmem_resp_valid,
        output stall, bubble, load_pending, timeout_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Dual source-register comparator: flags a decode instruction that reads a pending destination.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic      valid_i,
    input  reg_addr_t rs1_i,
    input  reg_addr_t rs2_i,
    input  logic      uses_rs1_i,
    input  logic      uses_rs2_i,
    input  reg_addr_t rd_i,
    output logic      hz_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = uses_rs1_i && (rs1_i == rd_i);
    assign rs2_hit = uses_rs2_i && (rs2_i == rd_i);

    // x0 is hard-wired, so a write to it never creates a dependency.
    assign hz_o = valid_i && (rs1_hit || rs2_hit) && (rd_i != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencing: load-use stalls, taken-jump flush bubbles and load-response timeout.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_INIT      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    // The jump cycle is the first bubble and the last FLUSH cycle sees a zero count.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_q,       state_d;
    reg_addr_t  pend_rd_q,     pend_rd_d;
    logic [7:0] wait_cnt_q,    wait_cnt_d;
    logic [3:0] flush_cnt_q,   flush_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    logic hz;
    logic load_stall;
    logic stall;
    logic bubble;

    hazard_cmp u_hazard_cmp (
        .valid_i    (bus.dec_valid),
        .rs1_i      (bus.dec_rs1),
        .rs2_i      (bus.dec_rs2),
        .uses_rs1_i (bus.dec_uses_rs1),
        .uses_rs2_i (bus.dec_uses_rs2),
        .rd_i       (pend_rd_q),
        .hz_o       (hz)
    );

    assign load_stall = bus.dec_valid && (hz || bus.dec_is_mem || bus.dec_is_jump);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d       = state_q;
        pend_rd_d     = pend_rd_q;
        wait_cnt_d    = wait_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        timeout_err_d = timeout_err_q;
        stall         = 1'b0;
        bubble        = 1'b0;

        case (state_q)
            ST_INIT: begin
                bubble  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.ex_jump_taken) begin
                    bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (bus.ex_mem_rr) begin
                    pend_rd_d  = bus.ex_rd;
                    wait_cnt_d = '0;
                    state_d    = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                stall  = load_stall;
                bubble = load_stall;
                // A response arriving on the final wait cycle still counts as success.
                if (bus.dmem_resp_valid) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                bubble = 1'b1;
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                bubble  = 1'b1;
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            pend_rd_q     <= REG_ZERO;
            wait_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q       <= state_d;
            pend_rd_q     <= pend_rd_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.bubble       = bubble;
    assign bus.load_pending = (state_q == ST_LOAD_WAIT);
    assign bus.timeout_err  = timeout_err_q;

endmodule
